// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB.
// Drives the shared datapath selects and the PC/IR load strobes.
// Memory phases stall on the mem_ready handshake.
module multicycle_control #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       write_enable_mem,
  output logic       write_enable_reg,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] opALU,
  output logic       illegal_op,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_MUL   = 6'b011100;

  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ANDI) ||
           (op == OP_ORI)   || (op == OP_XORI) || (op == OP_LW)   ||
           (op == OP_SW)    || (op == OP_MUL);
  endfunction

  // State, latched opcode and MUL hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      op_q      <= '0;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Next-state and per-state datapath controls; everything forced low during reset.
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    mul_cnt_d        = mul_cnt_q;
    pc_write         = 1'b0;
    ir_write         = 1'b0;
    i_or_d           = 1'b0;
    mem_read         = 1'b0;
    write_enable_mem = 1'b0;
    write_enable_reg = 1'b0;
    reg_dst          = 1'b0;
    mem_to_reg       = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = 2'b00;
    opALU            = 4'd0;
    illegal_op       = 1'b0;
    state            = state_q;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        opALU     = 4'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        op_d = opcode;
        if (is_legal(opcode)) begin
          state_d = EXEC;
        end else begin
          illegal_op = 1'b1;
          state_d    = FETCH;
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        case (op_q)
          OP_RTYPE, OP_MUL: begin alu_src_b = 2'b00; opALU = 4'd0; end
          OP_ADDI, OP_LW, OP_SW: begin alu_src_b = 2'b10; opALU = 4'd1; end
          OP_ANDI: begin alu_src_b = 2'b10; opALU = 4'd3; end
          OP_ORI:  begin alu_src_b = 2'b10; opALU = 4'd4; end
          OP_XORI: begin alu_src_b = 2'b10; opALU = 4'd5; end
          default: ;
        endcase
        if ((op_q == OP_MUL) && (mul_cnt_q != MUL_LAST)) begin
          mul_cnt_d = mul_cnt_q + 4'd1;
        end else begin
          mul_cnt_d = '0;
          state_d   = ((op_q == OP_LW) || (op_q == OP_SW)) ? MEM : WB;
        end
      end
      MEM: begin
        i_or_d           = 1'b1;
        mem_read         = (op_q == OP_LW);
        write_enable_mem = (op_q == OP_SW);
        if (mem_ready) state_d = (op_q == OP_SW) ? FETCH : WB;
      end
      WB: begin
        write_enable_reg = 1'b1;
        reg_dst          = (op_q == OP_RTYPE) || (op_q == OP_MUL);
        mem_to_reg       = (op_q == OP_LW);
        state_d          = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (rst) begin
      pc_write         = 1'b0;
      ir_write         = 1'b0;
      i_or_d           = 1'b0;
      mem_read         = 1'b0;
      write_enable_mem = 1'b0;
      write_enable_reg = 1'b0;
      reg_dst          = 1'b0;
      mem_to_reg       = 1'b0;
      alu_src_a        = 1'b0;
      alu_src_b        = 2'b00;
      opALU            = 4'd0;
      illegal_op       = 1'b0;
      state            = 3'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into the
// per-cycle phase list implied by the instruction's rules, and every cycle's
// full control vector is compared against a table-driven reference.
module tb_multicycle_control;
  localparam int unsigned MC = 4;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;
  localparam logic [5:0] R_OP = 6'b000000, ADDI = 6'b001000, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, XORI = 6'b001110, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, MUL = 6'b011100;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, ir_write, i_or_d, mem_read, write_enable_mem;
  logic       write_enable_reg, reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] alu_src_b;
  logic [3:0] opALU;
  logic [2:0] state;
  logic [18:0] dut_vec;

  int checks = 0;
  int passes = 0;

  multicycle_control #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .write_enable_mem(write_enable_mem),
    .write_enable_reg(write_enable_reg), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .opALU(opALU), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign dut_vec = {state, pc_write, ir_write, i_or_d, mem_read, write_enable_mem,
                    write_enable_reg, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                    opALU, illegal_op};

  function automatic logic legal(input logic [5:0] op);
    return op inside {R_OP, ADDI, ANDI, ORI, XORI, LW, SW, MUL};
  endfunction

  // Expected control vector for one cycle of a given phase.
  function automatic logic [18:0] model(input logic [2:0] st, input logic [5:0] op,
                                        input logic rdy);
    logic pcw, irw, iod, mr, wm, wr, rd, m2r, a, ill;
    logic [1:0] b;
    logic [3:0] alu;
    {pcw, irw, iod, mr, wm, wr, rd, m2r, a, ill} = '0;
    b = 2'b00;
    alu = 4'd0;
    case (st)
      S_F: begin mr = 1'b1; b = 2'b01; alu = 4'd1; pcw = rdy; irw = rdy; end
      S_D: ill = !legal(op);
      S_E: begin
        a = 1'b1;
        if (op == ADDI || op == LW || op == SW) begin b = 2'b10; alu = 4'd1; end
        else if (op == ANDI) begin b = 2'b10; alu = 4'd3; end
        else if (op == ORI)  begin b = 2'b10; alu = 4'd4; end
        else if (op == XORI) begin b = 2'b10; alu = 4'd5; end
      end
      S_M: begin iod = 1'b1; mr = (op == LW); wm = (op == SW); end
      S_W: begin wr = 1'b1; rd = (op == R_OP || op == MUL); m2r = (op == LW); end
      default: ;
    endcase
    return {st, pcw, irw, iod, mr, wm, wr, rd, m2r, a, b, alu, ill};
  endfunction

  // Runs one instruction from FETCH; fw/mw are memory wait cycles. If abort_at
  // is non-negative, reset is asserted for 2 cycles at that cycle index instead.
  task automatic run_instr(input string name, input logic [5:0] op, input int fw,
                           input int mw, input int abort_at);
    logic [2:0] ph[$];
    logic rdy;
    logic [18:0] exp_v;
    for (int i = 0; i < fw; i++) ph.push_back(S_F);
    ph.push_back(S_F);
    ph.push_back(S_D);
    if (legal(op)) begin
      for (int i = 0; i < ((op == MUL) ? int'(MC) : 1); i++) ph.push_back(S_E);
      if (op == LW || op == SW) begin
        for (int i = 0; i <= mw; i++) ph.push_back(S_M);
      end
      if (op != SW) ph.push_back(S_W);
    end
    for (int i = 0; i < ph.size(); i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        for (int j = 0; j < 2; j++) begin
          if (j > 0) @(negedge clk);
          rst = 1'b1;
          mem_ready = 1'($urandom);
          opcode = 6'($urandom);
          #1;
          checks++;
          if (dut_vec !== 19'd0) $display("FAIL %s reset-hold cyc%0d got %h exp %h", name, j, dut_vec, 19'd0);
          else passes++;
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        exp_v = model(S_F, op, 1'b0);
        checks++;
        if (dut_vec !== exp_v) $display("FAIL %s post-reset got %h exp %h", name, dut_vec, exp_v);
        else passes++;
        return;
      end
      if (ph[i] == S_F || ph[i] == S_M)
        rdy = (i == ph.size() - 1) || (ph[i+1] != ph[i]);
      else
        rdy = 1'($urandom);
      mem_ready = rdy;
      opcode = (ph[i] == S_D) ? op : 6'($urandom);
      #1;
      exp_v = model(ph[i], op, rdy);
      checks++;
      if (dut_vec !== exp_v) $display("FAIL %s op=%b cyc%0d got %h exp %h", name, op, i, dut_vec, exp_v);
      else passes++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = SW;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      #1;
      checks++;
      if (dut_vec !== 19'd0) $display("FAIL reset cyc%0d got %h exp %h", j, dut_vec, 19'd0);
      else passes++;
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== S_F || mem_read !== 1'b1) $display("FAIL reset_exit state got %0d exp 0 mem_read got %b exp 1", state, mem_read);
    else passes++;
  endtask

  task automatic test_sw_reset_in_mem();
    run_instr("sw_abort", SW, 0, 3, 4);
    run_instr("after_abort", ADDI, 3, 0, -1);
  endtask

  task automatic test_addi();      run_instr("addi", ADDI, 0, 0, -1);    endtask
  task automatic test_lw_wait();   run_instr("lw_wait", LW, 0, 3, -1);   endtask
  task automatic test_mul();       run_instr("mul", MUL, 0, 0, -1);      endtask
  task automatic test_illegal();   run_instr("illegal", 6'b111111, 0, 0, -1); endtask
  task automatic test_fetch_wait(); run_instr("fetch_wait", ORI, 2, 0, -1); endtask
  task automatic test_mul_abort(); run_instr("mul_abort", MUL, 1, 0, 5); endtask

  task automatic test_back_to_back();
    logic [5:0] ops[8];
    logic [5:0] op;
    int ab;
    ops = '{R_OP, ADDI, ANDI, ORI, XORI, LW, SW, MUL};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 7)];
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : -1;
      run_instr("random", op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ab);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = '0;
    test_reset();
    test_addi();
    test_lw_wait();
    test_mul();
    test_illegal();
    test_fetch_wait();
    test_sw_reset_in_mem();
    test_mul_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
